// File: rtl/regseq_pkg.sv
// Shared constants for the register-file operation sequencer: widths, opcodes,
// FSM encoding and the address range check.
package regseq_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned OP_W     = 3;

  localparam logic [OP_W-1:0] OP_NOP = 3'd0;
  localparam logic [OP_W-1:0] OP_MOV = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD = 3'd2;
  localparam logic [OP_W-1:0] OP_SUB = 3'd3;
  localparam logic [OP_W-1:0] OP_AND = 3'd4;
  localparam logic [OP_W-1:0] OP_OR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XOR = 3'd6;
  localparam logic [OP_W-1:0] OP_LDI = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return a >= ADDR_W'(NUM_REGS);
  endfunction

endpackage

// File: rtl/regfile_op_sequencer_if.sv
// Operation handshake plus register file port bundle; slave is the sequencer view.
interface regfile_op_sequencer_if
  import regseq_pkg::*;
  ;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [ADDR_W-1:0] in_rd;
  logic [ADDR_W-1:0] in_rs1;
  logic [ADDR_W-1:0] in_rs2;
  logic [DATA_W-1:0] in_imm;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [ADDR_W-1:0] rf_rd_addr_a;
  logic [DATA_W-1:0] rf_rd_data_a;
  logic [ADDR_W-1:0] rf_rd_addr_b;
  logic [DATA_W-1:0] rf_rd_data_b;
  logic              done;
  logic              done_err;
  logic              flag_z;
  logic              flag_c;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, rf_rd_data_a, rf_rd_data_b,
    output in_ready, rf_write, rf_wr_addr, rf_wr_data, rf_rd_addr_a, rf_rd_addr_b,
           done, done_err, flag_z, flag_c
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, rf_rd_data_a, rf_rd_data_b,
    input  in_ready, rf_write, rf_wr_addr, rf_wr_data, rf_rd_addr_a, rf_rd_addr_b,
           done, done_err, flag_z, flag_c
  );

endinterface

// File: rtl/regseq_alu.sv
// Combinational ALU for the sequencer; NOP passes a through and is gated by the caller.
module regseq_alu
  import regseq_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              z
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    // The extra MSB of the widened difference is the unsigned borrow (a < b).
    diff   = {1'b0, a} - {1'b0, b};
    result = a;
    c      = 1'b0;
    case (op)
      OP_MOV: result = a;
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        c      = diff[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_LDI: result = imm;
      default: result = a;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Four-phase sequencer (accept, read, execute, write back) that owns all
// register file port traffic.
module regfile_op_sequencer
  import regseq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  regfile_op_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_c_q, flag_c_d;
  logic              in_ready_q, in_ready_d;
  logic              rf_write_q, rf_write_d;
  logic              done_q, done_d;
  logic              done_err_q, done_err_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_c;
  logic              alu_z;
  logic              err_c;

  regseq_alu u_alu (
    .op     (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .imm    (imm_q),
    .result (alu_result),
    .c      (alu_c),
    .z      (alu_z)
  );

  // Only the addresses an opcode actually uses can raise an error.
  always_comb begin
    err_c = 1'b0;
    case (op_q)
      OP_NOP: err_c = 1'b0;
      OP_LDI: err_c = addr_bad(rd_q);
      OP_MOV: err_c = addr_bad(rd_q) | addr_bad(rs1_q);
      default: err_c = addr_bad(rd_q) | addr_bad(rs1_q) | addr_bad(rs2_q);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    imm_d      = imm_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    result_d   = result_q;
    flag_z_d   = flag_z_q;
    flag_c_d   = flag_c_q;
    in_ready_d = in_ready_q;
    rf_write_d = 1'b0;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          op_d       = bus.in_op;
          rd_d       = bus.in_rd;
          rs1_d      = bus.in_rs1;
          rs2_d      = bus.in_rs2;
          imm_d      = bus.in_imm;
          addr_a_d   = bus.in_rs1;
          addr_b_d   = bus.in_rs2;
          in_ready_d = 1'b0;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        opa_d   = bus.rf_rd_data_a;
        opb_d   = bus.rf_rd_data_b;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (op_q != OP_NOP) begin
          result_d = alu_result;
          flag_z_d = alu_z;
          flag_c_d = alu_c;
        end
        // Write-phase outputs are set up here so they are flops during WRITE.
        wr_addr_d  = rd_q;
        rf_write_d = (op_q != OP_NOP) && !err_c;
        done_d     = 1'b1;
        done_err_d = err_c;
        state_d    = ST_WRITE;
      end
      ST_WRITE: begin
        in_ready_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      result_q   <= '0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      in_ready_q <= 1'b1;
      rf_write_q <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      wr_addr_q  <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      imm_q      <= imm_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      result_q   <= result_d;
      flag_z_q   <= flag_z_d;
      flag_c_q   <= flag_c_d;
      in_ready_q <= in_ready_d;
      rf_write_q <= rf_write_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
      wr_addr_q  <= wr_addr_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.rf_write     = rf_write_q;
  assign bus.rf_wr_addr   = wr_addr_q;
  assign bus.rf_wr_data   = result_q;
  assign bus.rf_rd_addr_a = addr_a_q;
  assign bus.rf_rd_addr_b = addr_b_q;
  assign bus.done         = done_q;
  assign bus.done_err     = done_err_q;
  assign bus.flag_z       = flag_z_q;
  assign bus.flag_c       = flag_c_q;

endmodule
